// File: rtl/regfile_writeback_arbiter.sv
// Single register-file write port master: ALU results have priority, LSU results queue in a FIFO.
// Latency: ALU result on the port 1 cycle after acceptance; LSU result at least 2 cycles after push.
// Backpressure: lsu_ready drops when the FIFO is full; alu_stall asserts when the FIFO head has starved too long.
module regfile_writeback_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_stall,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    input  logic        lsu_issue_valid,
    input  logic [4:0]  lsu_issue_rd,
    output logic [31:0] pending,
    output logic        RegWrite,
    output logic [4:0]  RD,
    output logic [31:0] WriteData
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_ent_t;

    wb_ent_t        mem [DEPTH];
    wb_ent_t        head;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  starve_cnt;
    logic           fifo_empty;
    logic           fifo_full;
    logic           push;
    logic           pop;
    logic           use_alu;
    logic [31:0]    set_mask;
    logic [31:0]    clr_mask;
    logic [31:0]    pending_nxt;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head       = mem[rd_ptr[AW-1:0]];

    assign lsu_ready = rstn && !fifo_full;
    assign alu_stall = rstn && !fifo_empty && (starve_cnt == CW'(STARVE_LIMIT));

    assign push    = lsu_valid && lsu_ready;
    assign pop     = rstn && (alu_stall || (!alu_valid && !fifo_empty));
    assign use_alu = rstn && !alu_stall && alu_valid;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= '{rd: lsu_rd, data: lsu_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            starve_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (pop || fifo_empty) begin
                starve_cnt <= '0;
            end else if (starve_cnt != CW'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + CW'(1);
            end
        end
    end

    // Set beats clear so a reissued load to a just-retiring rd stays tracked.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (lsu_issue_valid && (lsu_issue_rd != 5'd0)) begin
            set_mask[lsu_issue_rd] = 1'b1;
        end
        if (pop) begin
            clr_mask[head.rd] = 1'b1;
        end
        pending_nxt = ((pending & ~clr_mask) | set_mask) & ~32'h1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // x0 writes still load RD/WriteData but never assert the enable.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            RegWrite  <= 1'b0;
            RD        <= '0;
            WriteData <= '0;
        end else if (pop) begin
            RegWrite  <= (head.rd != 5'd0);
            RD        <= head.rd;
            WriteData <= head.data;
        end else if (use_alu) begin
            RegWrite  <= (alu_rd != 5'd0);
            RD        <= alu_rd;
            WriteData <= alu_data;
        end else begin
            RegWrite  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench for regfile_writeback_arbiter: expected port writes are queued at stimulus time
// and a negedge monitor retires them; cycle-specific flags are checked inline.
module tb_regfile_writeback_arbiter;

    logic        clk;
    logic        rstn;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        lsu_issue_valid;
    logic [4:0]  lsu_issue_rd;
    logic [31:0] pending;
    logic        RegWrite;
    logic [4:0]  RD;
    logic [31:0] WriteData;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    regfile_writeback_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .alu_valid       (alu_valid),
        .alu_rd          (alu_rd),
        .alu_data        (alu_data),
        .alu_stall       (alu_stall),
        .lsu_valid       (lsu_valid),
        .lsu_ready       (lsu_ready),
        .lsu_rd          (lsu_rd),
        .lsu_data        (lsu_data),
        .lsu_issue_valid (lsu_issue_valid),
        .lsu_issue_rd    (lsu_issue_rd),
        .pending         (pending),
        .RegWrite        (RegWrite),
        .RD              (RD),
        .WriteData       (WriteData)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every enabled write must match the next queued expectation, in order.
    always @(negedge clk) begin
        if (RegWrite === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL port_write: unexpected write rd=%0d data=%h", RD, WriteData);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (RD !== e.rd || WriteData !== e.data) begin
                    errors++;
                    $display("FAIL port_write: got rd=%0d data=%h expected rd=%0d data=%h",
                             RD, WriteData, e.rd, e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
        exp_q.push_back('{rd: rd, data: data});
    endtask

    initial begin
        rstn = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        lsu_issue_valid = 1'b0; lsu_issue_rd = '0;
        step();
        step();
        chk("rst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
        chk("rst_alu_stall", {31'd0, alu_stall}, 32'd0);
        chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("rst_rd", {27'd0, RD}, 32'd0);
        chk("rst_wdata", WriteData, 32'd0);
        chk("rst_pending", pending, 32'd0);
        rstn = 1'b1;
        #1;
        chk("post_rst_lsu_ready", {31'd0, lsu_ready}, 32'd1);

        // ALU write, then idle: RD and WriteData hold
        expect_wr(5'd5, 32'hDEADBEEF);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        alu_valid = 1'b0;
        chk("alu_regwrite", {31'd0, RegWrite}, 32'd1);
        chk("alu_rd", {27'd0, RD}, 32'd5);
        step();
        chk("idle_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("idle_rd_hold", {27'd0, RD}, 32'd5);
        chk("idle_wdata_hold", WriteData, 32'hDEADBEEF);

        // LSU load: pending set on issue, cleared with the port write 2 cycles after push
        lsu_issue_valid = 1'b1; lsu_issue_rd = 5'd7;
        step();
        lsu_issue_valid = 1'b0;
        chk("pend_set7", pending, 32'h0000_0080);
        expect_wr(5'd7, 32'h12345678);
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h12345678;
        step();
        lsu_valid = 1'b0;
        chk("lsu_not_yet", {31'd0, RegWrite}, 32'd0);
        chk("pend_still7", pending, 32'h0000_0080);
        step();
        chk("lsu_regwrite", {31'd0, RegWrite}, 32'd1);
        chk("lsu_rd", {27'd0, RD}, 32'd7);
        chk("pend_clr7", pending, 32'd0);

        // Starvation: ALU streams, two LSU entries fill the FIFO, head wins after 4 lost cycles
        for (int i = 0; i < 5; i++) expect_wr(5'd12, 32'hC000_0000 + 32'(i));
        expect_wr(5'd10, 32'hA1A1_A1A1);
        expect_wr(5'd12, 32'hC000_0005);
        expect_wr(5'd11, 32'hA2A2_A2A2);
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC000_0000;
        lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'hA1A1_A1A1;
        #1;
        chk("stv_ready0", {31'd0, lsu_ready}, 32'd1);
        step();
        alu_data = 32'hC000_0001;
        lsu_rd = 5'd11; lsu_data = 32'hA2A2_A2A2;
        step();
        lsu_valid = 1'b0;
        alu_data = 32'hC000_0002;
        #1;
        chk("stv_full", {31'd0, lsu_ready}, 32'd0);
        chk("stv_nostall", {31'd0, alu_stall}, 32'd0);
        step();
        alu_data = 32'hC000_0003;
        step();
        alu_data = 32'hC000_0004;
        #1;
        chk("stv_nostall4", {31'd0, alu_stall}, 32'd0);
        step();
        alu_data = 32'hC000_0005;
        #1;
        chk("stv_stall", {31'd0, alu_stall}, 32'd1);
        step();
        #1;
        chk("stv_stall_drop", {31'd0, alu_stall}, 32'd0);
        chk("stv_head_rd", {27'd0, RD}, 32'd10);
        step();
        alu_valid = 1'b0;
        chk("stv_alu_rd", {27'd0, RD}, 32'd12);
        chk("stv_alu_data", WriteData, 32'hC000_0005);
        step();
        chk("stv_tail_rd", {27'd0, RD}, 32'd11);
        chk("stv_ready_back", {31'd0, lsu_ready}, 32'd1);

        // x0 writes: enable stays low, values still load, FIFO entry still pops
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_0055;
        step();
        alu_valid = 1'b0;
        chk("x0_alu_we", {31'd0, RegWrite}, 32'd0);
        chk("x0_alu_rd", {27'd0, RD}, 32'd0);
        chk("x0_alu_data", WriteData, 32'h0000_0055);
        expect_wr(5'd3, 32'h0000_0077);
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h0000_0066;
        step();
        lsu_rd = 5'd3; lsu_data = 32'h0000_0077;
        step();
        lsu_valid = 1'b0;
        chk("x0_lsu_we", {31'd0, RegWrite}, 32'd0);
        chk("x0_lsu_data", WriteData, 32'h0000_0066);
        step();
        chk("after_x0_rd", {27'd0, RD}, 32'd3);

        // Reissue of rd=9 in the cycle its writeback retires: set wins
        lsu_issue_valid = 1'b1; lsu_issue_rd = 5'd9;
        step();
        lsu_issue_valid = 1'b0;
        chk("pend_set9", pending, 32'h0000_0200);
        expect_wr(5'd9, 32'h0000_0099);
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h0000_0099;
        step();
        lsu_valid = 1'b0;
        lsu_issue_valid = 1'b1; lsu_issue_rd = 5'd9;
        step();
        lsu_issue_valid = 1'b0;
        chk("setwin_rd", {27'd0, RD}, 32'd9);
        chk("setwin_pend", pending, 32'h0000_0200);

        // Reset mid-burst drops buffered entries and pending bits
        lsu_issue_valid = 1'b1; lsu_issue_rd = 5'd7;
        step();
        lsu_issue_valid = 1'b0;
        chk("pend_280", pending, 32'h0000_0280);
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0;
        lsu_valid = 1'b1; lsu_rd = 5'd13; lsu_data = 32'h1313_1313;
        step();
        lsu_rd = 5'd14; lsu_data = 32'h1414_1414;
        step();
        lsu_valid = 1'b0;
        chk("burst_full", {31'd0, lsu_ready}, 32'd0);
        rstn = 1'b0;
        alu_valid = 1'b0;
        #1;
        chk("rstlow_ready", {31'd0, lsu_ready}, 32'd0);
        chk("rstlow_stall", {31'd0, alu_stall}, 32'd0);
        step();
        chk("midrst_we", {31'd0, RegWrite}, 32'd0);
        chk("midrst_pend", pending, 32'd0);
        rstn = 1'b1;
        #1;
        chk("midrst_ready", {31'd0, lsu_ready}, 32'd1);
        for (int i = 0; i < 4; i++) step();
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_writeback_arbiter.md
Name: regfile_writeback_arbiter

Overview:
- Write-side master for the CPU's single register-file write port; drives RegWrite/RD/WriteData.
- Merges single-cycle ALU results with long-latency LSU results: ALU has priority; LSU results wait in a small FIFO.
- Keeps a pending-destination scoreboard for outstanding LSU loads, so issue logic can stall on RAW hazards.
- Includes a starvation guard so buffered LSU results always retire.

Parameters:
- DEPTH, 2, LSU result FIFO entries (power of two, >=2)
- STARVE_LIMIT, 4, max consecutive cycles a non-empty FIFO head may lose to the ALU before the ALU is stalled

Ports:
- clk  in  1  clock, all state updates on rising edge
- rstn  in  1  synchronous active-low reset
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- alu_stall  out  1  ALU result not accepted this cycle; producer holds alu_* stable
- lsu_valid  in  1  LSU result offered
- lsu_ready  out  1  FIFO can accept LSU result
- lsu_rd  in  5  LSU destination register
- lsu_data  in  32  LSU result
- lsu_issue_valid  in  1  LSU load issued this cycle
- lsu_issue_rd  in  5  destination of issued load
- pending  out  32  bit i set = register i awaits an LSU writeback; bit 0 always 0
- RegWrite  out  1  register-file write enable (registered)
- RD  out  5  write address (registered)
- WriteData  out  32  write data (registered)

Behaviour:
- Reset (rstn low at posedge):
  - RegWrite=0, RD=0, WriteData=0, pending=0.
  - FIFO emptied, starve counter=0.
  - lsu_ready=0 and alu_stall=0 combinationally while rstn is low.
  - Reset mid-operation drops all buffered results and pending bits.
- lsu_ready = !fifo_full; there is no bypass around the FIFO.
  - Push on lsu_valid && lsu_ready.
- alu_stall = fifo_nonempty && (starve_cnt == STARVE_LIMIT). Combinational.
- Write-port selection each cycle, in priority order; outputs register on the next edge:
  1. alu_stall=1: pop FIFO head, write it.
  2. alu_valid=1: write ALU result; FIFO is not popped.
  3. FIFO non-empty: pop head, write it.
  4. Otherwise RegWrite<=0; RD and WriteData hold their previous values.
- Latency:
  - ALU result appears on the port 1 cycle after acceptance.
  - LSU result appears at least 2 cycles after push (FIFO, then output register).
- x0 writes:
  - A selected write with rd==0 still consumes its slot/pop, but RegWrite<=0.
  - RD and WriteData still load the selected values.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) on cycles where the FIFO is non-empty and not popped.
  - Clears on every pop and whenever the FIFO is empty.
- Simultaneous push and pop are allowed when the FIFO is not full.
  - Occupancy is unchanged; entry order is preserved.
- Scoreboard:
  - Set bit lsu_issue_rd on lsu_issue_valid when rd!=0.
  - Clear bit rd when an LSU entry with that rd is written to the port (registered with RegWrite).
  - Set and clear of the same bit in the same cycle: set wins.
  - One bit per register: issue logic must not issue a second load to a pending rd. Behaviour in that case is undefined.
- The FIFO, counters and pointers wrap modulo DEPTH; pointer width is log2(DEPTH)+1 for full/empty detection.

Test Plan:
- Reset, then alu_valid with rd=5, data=0xDEADBEEF -> next cycle RegWrite=1, RD=5, WriteData=0xDEADBEEF; following cycle RegWrite=0, RD holds 5.
- LSU push rd=7, data=0x12345678 with FIFO empty and ALU idle; earlier lsu_issue_valid rd=7 -> pending[7]=1 until the cycle RegWrite=1/RD=7 appears (2 cycles after push), then pending[7]=0.
- Two LSU pushes (DEPTH=2) with alu_valid held high -> lsu_ready=0 after the 2nd push; after 4 lost cycles alu_stall=1 for one cycle, LSU head written, ALU result written next cycle unchanged.
- ALU write to rd=0 and LSU write to rd=0 -> RegWrite stays 0; the FIFO entry is still popped.
- Same cycle: lsu_issue_valid rd=9 and LSU writeback of rd=9 retiring -> pending[9]=1 afterward.
- rstn low mid-burst with 2 FIFO entries and pending=0x00000280 -> next cycle RegWrite=0, pending=0, FIFO empty, lsu_ready=1 after rstn returns high.
